// File: rtl/gpio_cond_pkg.sv
// Shared register offsets and sizing helper for the GPIO input conditioner.
`timescale 1ns/1ps
package gpio_cond_pkg;

    localparam logic [4:0] REG_PRESCALE = 5'h00;
    localparam logic [4:0] REG_BYPASS   = 5'h04;
    localparam logic [4:0] REG_RAW      = 5'h08;
    localparam logic [4:0] REG_CLEAN    = 5'h0C;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= n) return w;
        end
        return 32;
    endfunction

endpackage

// File: rtl/gpio_input_conditioner_debounce_cell.sv
// Single-pin debounce filter: accepts a new level after STABLE_SAMPLES
// consecutive mismatching ticks, or follows the sample directly when bypassed.
`timescale 1ns/1ps
module gpio_debounce_cell
    import gpio_cond_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic bypass_i,
    input  logic sample_i,
    output logic clean_o,
    output logic chg_o
);

    localparam int CW = cnt_width(STABLE_SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          chg_q, chg_d;

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        // Bypass keeps the counter at zero so leaving bypass filters from scratch.
        if (bypass_i) begin
            clean_d = sample_i;
            cnt_d   = '0;
        end else if (tick_i) begin
            if (sample_i == clean_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                clean_d = sample_i;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        chg_d = clean_d ^ clean_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            chg_q   <= chg_d;
        end
    end

    assign clean_o = clean_q;
    assign chg_o   = chg_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input front-end: 2-FF synchronizer, shared sample-tick prescaler,
// per-pin debounce filters and a small register window.
`timescale 1ns/1ps
module gpio_input_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int NPINS            = 32,
    parameter int STABLE_SAMPLES   = 4,
    parameter int PRESCALE_DEFAULT = 3,
    parameter int PRESCALE_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       addr_i,
    input  logic             write_en,
    input  logic             read_en,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [NPINS-1:0] pad_in,
    output logic [NPINS-1:0] gpio_clean,
    output logic [NPINS-1:0] gpio_chg
);

    logic [NPINS-1:0]      sync1_q, sync2_q;
    logic [NPINS-1:0]      bypass_q, bypass_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  wr_prescale, wr_bypass, tick;

    assign wr_prescale = write_en && (addr_i == REG_PRESCALE);
    assign wr_bypass   = write_en && (addr_i == REG_BYPASS);

    // A PRESCALE write restarts the period and suppresses the tick on that edge.
    always_comb begin
        tick   = 1'b0;
        pcnt_d = pcnt_q + PRESCALE_W'(1);
        if (wr_prescale) begin
            pcnt_d = '0;
        end else if (pcnt_q == prescale_q) begin
            tick   = 1'b1;
            pcnt_d = '0;
        end
    end

    always_comb begin
        prescale_d = wr_prescale ? PRESCALE_W'(wdata) : prescale_q;
        bypass_d   = wr_bypass   ? NPINS'(wdata)      : bypass_q;
        rdata_d    = rdata_q;
        if (read_en) begin
            case (addr_i)
                REG_PRESCALE: rdata_d = 32'(prescale_q);
                REG_BYPASS:   rdata_d = 32'(bypass_q);
                REG_RAW:      rdata_d = 32'(sync2_q);
                REG_CLEAN:    rdata_d = 32'(gpio_clean);
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            bypass_q   <= '0;
            prescale_q <= PRESCALE_W'(PRESCALE_DEFAULT);
            pcnt_q     <= '0;
            rdata_q    <= '0;
        end else begin
            sync1_q    <= pad_in;
            sync2_q    <= sync1_q;
            bypass_q   <= bypass_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata = rdata_q;

    for (genvar gi = 0; gi < NPINS; gi++) begin : g_cell
        gpio_debounce_cell #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_i   (tick),
            .bypass_i (bypass_q[gi]),
            .sample_i (sync2_q[gi]),
            .clean_o  (gpio_clean[gi]),
            .chg_o    (gpio_chg[gi])
        );
    end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed self-checking bench for gpio_input_conditioner.
`timescale 1ns/1ps
module tb_gpio_input_conditioner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  addr_i = '0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [31:0] pad_in = '0;
    logic [31:0] gpio_clean;
    logic [31:0] gpio_chg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpio_input_conditioner #(
        .NPINS(32), .STABLE_SAMPLES(4), .PRESCALE_DEFAULT(3), .PRESCALE_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .write_en(write_en),
        .read_en(read_en), .wdata(wdata), .rdata(rdata), .pad_in(pad_in),
        .gpio_clean(gpio_clean), .gpio_chg(gpio_chg)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
        addr_i = a; wdata = d; write_en = 1'b1;
        step(1);
        write_en = 1'b0;
        $display("write addr=0x%02h data=0x%08h", a, d);
    endtask

    task automatic reg_read(input logic [4:0] a);
        addr_i = a; read_en = 1'b1;
        step(1);
        read_en = 1'b0;
        $display("read  addr=0x%02h data=0x%08h", a, rdata);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        checks++;
        if (gpio_clean !== 32'h0 || gpio_chg !== 32'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: clean=%h chg=%h rdata=%h, need all 0", gpio_clean, gpio_chg, rdata);
        end
        rst_n = 1'b1;
        reg_read(5'h00);
        checks++;
        if (rdata !== 32'h3) begin errors++; $display("FAIL reset_prescale: got %h need 00000003", rdata); end
        reg_read(5'h04);
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_bypass: got %h need 00000000", rdata); end
        reg_read(5'h00);
        reg_read(5'h10);
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h need 00000000", rdata); end
    endtask

    task automatic test_steady_rise;
        reg_write(5'h00, 32'h0);
        pad_in[8] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            checks++;
            if (k < 6) begin
                if (gpio_clean !== 32'h0 || gpio_chg !== 32'h0) begin
                    errors++;
                    $display("FAIL rise_early edge%0d: clean=%h chg=%h need 0", k - 1, gpio_clean, gpio_chg);
                end
            end else if (gpio_clean !== 32'h100 || gpio_chg !== 32'h100) begin
                errors++;
                $display("FAIL rise_E5: clean=%h chg=%h need 00000100", gpio_clean, gpio_chg);
            end
        end
        step(1);
        checks++;
        if (gpio_chg !== 32'h0 || gpio_clean !== 32'h100) begin
            errors++;
            $display("FAIL rise_chg_single: clean=%h chg=%h need 00000100/0", gpio_clean, gpio_chg);
        end
        reg_read(5'h0C);
        checks++;
        if (rdata !== 32'h100) begin errors++; $display("FAIL clean_reg: got %h need 00000100", rdata); end
        pad_in[8] = 1'b0;
        step(8);
        checks++;
        if (gpio_clean !== 32'h0) begin errors++; $display("FAIL fall_pin8: got %h need 0", gpio_clean); end
    endtask

    task automatic test_glitch;
        pad_in[3] = 1'b1;
        step(2);
        addr_i = 5'h08; read_en = 1'b1;
        step(1);
        read_en = 1'b0;
        pad_in[3] = 1'b0;
        checks++;
        if (rdata !== 32'h8) begin errors++; $display("FAIL raw_pulse: got %h need 00000008", rdata); end
        for (int k = 0; k < 12; k++) begin
            step(1);
            checks++;
            if (gpio_clean !== 32'h0 || gpio_chg !== 32'h0) begin
                errors++;
                $display("FAIL glitch_reject cyc%0d: clean=%h chg=%h need 0", k, gpio_clean, gpio_chg);
            end
        end
    endtask

    task automatic test_prescaled;
        reg_write(5'h00, 32'h3);
        pad_in[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            checks++;
            if (k < 16) begin
                if (gpio_clean[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL presc_early k=%0d: got %b need 0", k, gpio_clean[0]);
                end
            end else if (gpio_clean[0] !== 1'b1 || gpio_chg[0] !== 1'b1) begin
                errors++;
                $display("FAIL presc_rise k=16: clean=%b chg=%b need 1/1", gpio_clean[0], gpio_chg[0]);
            end
        end
        pad_in[0] = 1'b0;
        step(40);
        checks++;
        if (gpio_clean !== 32'h0) begin errors++; $display("FAIL presc_fall: got %h need 0", gpio_clean); end
        pad_in[0] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (k == 10) pad_in[0] = 1'b0;
            step(1);
            checks++;
            if (gpio_clean !== 32'h0 || gpio_chg !== 32'h0) begin
                errors++;
                $display("FAIL presc_pulse_reject cyc%0d: clean=%h chg=%h need 0", k, gpio_clean, gpio_chg);
            end
        end
    endtask

    task automatic test_bypass;
        logic nv;
        reg_write(5'h04, 32'h1);
        reg_read(5'h04);
        checks++;
        if (rdata !== 32'h1) begin errors++; $display("FAIL bypass_reg: got %h need 00000001", rdata); end
        for (int t = 0; t < 4; t++) begin
            nv = ~pad_in[0];
            pad_in[0] = nv;
            step(2);
            checks++;
            if (gpio_clean[0] !== ~nv) begin
                errors++;
                $display("FAIL bypass_early t%0d: got %b need %b", t, gpio_clean[0], ~nv);
            end
            step(1);
            checks++;
            if (gpio_clean[0] !== nv || gpio_chg[0] !== 1'b1) begin
                errors++;
                $display("FAIL bypass_follow t%0d: clean=%b chg=%b need %b/1", t, gpio_clean[0], gpio_chg[0], nv);
            end
            step(1);
            checks++;
            if (gpio_chg[0] !== 1'b0) begin
                errors++;
                $display("FAIL bypass_chg_single t%0d: got %b need 0", t, gpio_chg[0]);
            end
        end
        pad_in[0] = 1'b1;
        step(3);
        pad_in[0] = 1'b0;
        reg_write(5'h04, 32'h0);
        step(3);
        checks++;
        if (gpio_clean[0] !== 1'b1) begin
            errors++;
            $display("FAIL bypass_exit_hold: got %b need 1", gpio_clean[0]);
        end
        step(40);
        checks++;
        if (gpio_clean !== 32'h0) begin errors++; $display("FAIL bypass_exit_filter: got %h need 0", gpio_clean); end
    endtask

    task automatic test_back_to_back;
        addr_i = 5'h00; wdata = 32'h7; write_en = 1'b1; read_en = 1'b1;
        step(1);
        write_en = 1'b0; read_en = 1'b0;
        checks++;
        if (rdata !== 32'h3) begin errors++; $display("FAIL rw_same_old: got %h need 00000003", rdata); end
        reg_write(5'h10, 32'hFFFF_FFFF);
        reg_read(5'h00);
        checks++;
        if (rdata !== 32'h7) begin errors++; $display("FAIL rw_same_new: got %h need 00000007", rdata); end
        step(3);
        checks++;
        if (rdata !== 32'h7) begin errors++; $display("FAIL rdata_hold: got %h need 00000007", rdata); end
    endtask

    task automatic test_async_reset;
        reg_write(5'h00, 32'h0);
        pad_in[5] = 1'b1;
        step(8);
        checks++;
        if (gpio_clean !== 32'h20) begin errors++; $display("FAIL pre_reset_pin5: got %h need 00000020", gpio_clean); end
        pad_in[6] = 1'b1;
        step(4);
        rst_n = 1'b0;
        #1;
        checks++;
        if (gpio_clean !== 32'h0 || gpio_chg !== 32'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: clean=%h chg=%h rdata=%h need 0", gpio_clean, gpio_chg, rdata);
        end
        step(2);
        rst_n = 1'b1;
        reg_write(5'h00, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            checks++;
            if (k < 5) begin
                if (gpio_clean !== 32'h0) begin
                    errors++;
                    $display("FAIL requal_early k=%0d: got %h need 0", k, gpio_clean);
                end
            end else if (gpio_clean !== 32'h60 || gpio_chg !== 32'h60) begin
                errors++;
                $display("FAIL requal_rise: clean=%h chg=%h need 00000060", gpio_clean, gpio_chg);
            end
        end
        pad_in = '0;
    endtask

    initial begin
        test_reset;
        test_steady_rise;
        test_glitch;
        test_prescaled;
        test_bypass;
        test_back_to_back;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
